glip_packet_deframer: RTL
=========================

// Module: glip_packet_deframer
// PURPOSE
// - Consumes the host->device word stream leaving the GLIP TCP backend (fifo_in_*).
// - Splits it into length-prefixed packets and presents payload words with an end-of-packet marker.
// - Sits between the TCP backend and user logic in simulation top-levels.
// - Gives downstream logic packet boundaries that the raw GLIP FIFO interface lacks.
// PARAMETERS
// - WIDTH    16  word width; identical to the backend's WIDTH
// - CNT_W    32  width of the pkt_count statistics counter
// PORTS
// - clk_logic     in   1      logic clock
// - rst           in   1      reset: synchronous, active-high
// - logic_rst     in   1      soft reset from the backend control channel; same effect as rst
// - in_data       in   WIDTH  word from the backend (fifo_in_data)
// - in_valid      in   1      word valid (fifo_in_valid)
// - in_ready      out  1      word accepted (drives fifo_in_ready)
// - out_data      out  WIDTH  payload word
// - out_valid     out  1      payload word valid
// - out_last      out  1      last payload word of the packet; qualified by out_valid
// - out_ready     in   1      downstream accepts the payload word
// - pkt_count     out  CNT_W  number of packets fully delivered (last word accepted); wraps
// - err_zero_len  out  1      one-cycle pulse: a header with length 0 was consumed
// BEHAVIOUR
// - Reset: rst OR logic_rst, sampled on posedge clk_logic.
//   - Sets state=HDR, remaining=0, out_valid=0, out_last=0, out_data=0, pkt_count=0, err_zero_len=0.
//   - Reset asserted mid-packet discards the rest of the packet; no out_last is produced.
// - Transfer rule: a transfer occurs on valid&&ready at posedge, on each side independently.
// - State HDR: in_ready=1.
//   - Header word accepted: remaining <= in_data (unsigned, WIDTH bits).
//   - Nonzero length: go to PAY.
//   - Zero length: stay in HDR and pulse err_zero_len for one cycle.
//   - No output word is produced for a header.
// - State PAY: in_ready = !out_valid || out_ready (combinational from out_ready).
//   - On input transfer: out_data<=in_data, out_valid<=1, out_last<=(remaining==1), remaining<=remaining-1.
//   - When remaining reaches 0 after that transfer: go to HDR.
// - Output register: a single stage, so latency is 1 cycle from input transfer to out_valid.
//   - Full throughput: one word per cycle when out_ready is held high.
//   - Output transfer with no new input transfer in the same cycle: out_valid<=0, out_last<=0.
//   - Input and output transfer in the same cycle: the register is overwritten and out_valid stays 1.
// - Header accepted while the last payload word is still held in the output register: allowed.
//   - The header does not touch the output register.
//   - The next packet may start back-to-back.
// - pkt_count: increments on an output transfer with out_last=1.
//   - Wraps from 2^CNT_W-1 to 0.
// - Stall: while out_valid && !out_ready, out_data, out_valid and out_last hold stable.
// - Maximum length: 2^WIDTH-1; remaining never underflows.
// STRUCTURE
// - Package glip_deframer_pkg: typedef enum logic {HDR, PAY} state_t.
// - Sub-module glip_out_reg: one-entry valid/ready register with data+last payload.
//   - Ports: clk, clr, in_*, out_*, in_ready; clr = rst|logic_rst.
// - Top-level holds the FSM, the remaining counter, pkt_count and err_zero_len.
// TESTING
// - Basic: send words 3,A,B,C with out_ready=1.
//   - Expect out A,B,C on consecutive cycles; out_last only with C; pkt_count=1.
// - Back-to-back: send 1,X,2,Y,Z.
//   - Expect X(last), Y, Z(last); pkt_count=2; header cycles add no output bubbles beyond the header word.
// - Backpressure: send 4,D0..D3 with out_ready low for 3 cycles after D0 appears.
//   - Expect D0 held stable; in_ready=0 while stalled; no loss or duplication.
// - Zero length: send 0 then 1,E.
//   - Expect err_zero_len pulse exactly 1 cycle; then E with out_last; pkt_count=1.
// - Soft reset: send 5,F0,F1, then pulse logic_rst for 1 cycle.
//   - Expect out_valid=0 after the pulse; the next word 1,G is treated as a header and G is delivered with out_last.
// - Wrap: CNT_W=2 with 5 one-word packets; expect pkt_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/glip_deframer_pkg.sv
// Shared types for the GLIP packet deframer.
package glip_deframer_pkg;

    typedef enum logic {
        HDR,
        PAY
    } state_t;

endpackage

// File: rtl/glip_out_reg.sv
// One-entry valid/ready output register carrying a data word and a last flag.
module glip_out_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    // Accept when empty or when the held word leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/glip_packet_deframer.sv
// Splits the GLIP host->device word stream into length-prefixed packets with an
// end-of-packet marker on the last payload word.
module glip_packet_deframer
    import glip_deframer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_logic,
    input  logic             rst,
    input  logic             logic_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_count,
    output logic             err_zero_len
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic             clr;
    logic             reg_in_valid;
    logic             reg_in_ready;
    logic             in_xfer;
    logic             out_xfer;

    assign clr          = rst | logic_rst;
    assign reg_in_valid = (state == PAY) && in_valid;
    // Headers never touch the output register, so they are always accepted.
    assign in_ready     = (state == HDR) ? 1'b1 : reg_in_ready;
    assign in_xfer      = in_valid && in_ready;
    assign out_xfer     = out_valid && out_ready;

    always_ff @(posedge clk_logic) begin
        if (clr) begin
            state        <= HDR;
            remaining    <= '0;
            pkt_count    <= '0;
            err_zero_len <= 1'b0;
        end else begin
            err_zero_len <= 1'b0;
            if (out_xfer && out_last) begin
                pkt_count <= pkt_count + CNT_ONE;
            end
            if (in_xfer) begin
                unique case (state)
                    HDR: begin
                        remaining <= in_data;
                        if (in_data == '0) begin
                            err_zero_len <= 1'b1;
                        end else begin
                            state <= PAY;
                        end
                    end
                    PAY: begin
                        // PAY is only entered with remaining >= 1, so this cannot underflow.
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    glip_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk_logic),
        .clr      (clr),
        .in_data  (in_data),
        .in_last  (remaining == ONE),
        .in_valid (reg_in_valid),
        .in_ready (reg_in_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule
